// File: rtl/dmem_pkg.sv
// Shared types and constants for the synchronous data memory.
package dmem_pkg;

  localparam int unsigned LANE_W = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } dmem_state_e;

  // Legal configuration: whole byte lanes, at least one word, depth fits the address space.
  function automatic bit dmem_cfg_ok(input int unsigned data_w,
                                     input int unsigned addr_w,
                                     input int unsigned depth);
    bit ok;
    ok = (data_w != 0) && ((data_w % LANE_W) == 0) && (depth >= 1) && (addr_w >= 1)
         && (addr_w < 63) && (longint'(depth) <= (longint'(1) << addr_w));
    return ok;
  endfunction

endpackage

// File: rtl/dmem_sync_if.sv
// Request/response bus between the CPU load/store path and dmem_sync.
interface dmem_sync_if
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  localparam int unsigned BE_W = DATA_W / LANE_W;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage, byte-lane write enables, registered read that returns 0 when not reading.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [IDX_W-1:0]         addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [DATA_W/LANE_W-1:0] be_i,
  output logic [DATA_W-1:0]        rdata_o
);
  localparam int unsigned BE_W = DATA_W / LANE_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (be_i[i]) mem_q[addr_i][i*LANE_W +: LANE_W] <= wdata_i[i*LANE_W +: LANE_W];
      end
    end
    rdata_q <= re_i ? mem_q[addr_i] : '0;
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_sync.sv
// Synchronous data memory: zeroising clear after reset, valid/ready requests, one-cycle responses.
module dmem_sync
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic      clk,
  input  logic      rst_n,
  dmem_sync_if.slave bus
);
  localparam int unsigned BE_W  = DATA_W / LANE_W;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (!dmem_cfg_ok(DATA_W, ADDR_W, DEPTH)) begin : g_bad_cfg
    $error("dmem_sync: illegal DATA_W/ADDR_W/DEPTH combination");
  end

  dmem_state_e       state_q;
  logic [IDX_W-1:0]  clr_cnt_q;
  logic [IDX_W-1:0]  clr_cnt_d;
  logic              busy_q;
  logic              ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;

  logic              accept;
  logic              in_range;
  logic              clr_last;
  logic              arr_we;
  logic              arr_re;
  logic [IDX_W-1:0]  arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [BE_W-1:0]   arr_be;
  logic [DATA_W-1:0] arr_rdata;

  assign accept    = bus.req_valid && ready_q;
  assign in_range  = (32'(bus.req_addr) < DEPTH);
  assign clr_cnt_d = clr_cnt_q + IDX_W'(1);
  assign clr_last  = (clr_cnt_q == IDX_W'(DEPTH - 1));

  // The clear and live traffic share the single array port; the FSM state picks the owner.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = clr_cnt_q;
    arr_wdata = '0;
    arr_be    = '1;
    if (state_q == ST_RUN) begin
      arr_addr  = IDX_W'(bus.req_addr);
      arr_wdata = bus.req_wdata;
      arr_be    = bus.req_be;
      arr_we    = rst_n && accept && in_range && bus.req_we;
      arr_re    = rst_n && accept && in_range && !bus.req_we;
    end else begin
      arr_we    = rst_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= '0;
      busy_q      <= 1'b1;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          clr_cnt_q   <= clr_cnt_d;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          if (clr_last) begin
            state_q   <= ST_RUN;
            clr_cnt_q <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
          end
        end
        ST_RUN: begin
          rsp_valid_q <= accept;
          rsp_err_q   <= accept && !in_range;
        end
      endcase
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .be_i    (arr_be),
    .rdata_o (arr_rdata)
  );

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = arr_rdata;
endmodule

// File: tb/tb_dmem_sync.sv
// Randomized self-checking bench for dmem_sync against a word-array reference model.
module tb_dmem_sync;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dmem_sync_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dmem_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected outputs after each edge
  logic [15:0] mem_m [DEPTH];
  int          clr_left = DEPTH;
  bit          m_busy   = 1'b1;
  bit          m_ready  = 1'b0;
  bit          m_valid  = 1'b0;
  bit          m_err    = 1'b0;
  logic [15:0] m_rdata  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit v, input bit we, input logic [7:0] a,
                            input logic [15:0] d, input logic [1:0] be);
    if (!rst) begin
      clr_left = DEPTH;
      foreach (mem_m[i]) mem_m[i] = '0;
      m_busy = 1'b1; m_ready = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_rdata = '0;
    end else if (!m_ready) begin
      if (clr_left > 0) clr_left--;
      m_busy  = (clr_left != 0);
      m_ready = !m_busy;
      m_valid = 1'b0; m_err = 1'b0; m_rdata = '0;
    end else begin
      m_valid = v;
      m_err   = v && (int'(a) >= int'(DEPTH));
      m_rdata = '0;
      if (v && int'(a) < int'(DEPTH)) begin
        if (we) begin
          if (be[0]) mem_m[a][7:0]  = d[7:0];
          if (be[1]) mem_m[a][15:8] = d[15:8];
        end else begin
          m_rdata = mem_m[a];
        end
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit v, input bit we, input logic [7:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    rst_n         = rst;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    @(posedge clk);
    model_step(rst, v, we, a, d, be);
    @(negedge clk);
    check("busy",      32'(bus.busy),      32'(m_busy));
    check("req_ready", 32'(bus.req_ready), 32'(m_ready));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    check("rsp_err",   32'(bus.rsp_err),   32'(m_err));
    check("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
  endtask

  task automatic idle(input bit rst);
    cycle(rst, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    cycle(1'b1, 1'b1, 1'b1, a, d, be);
  endtask

  task automatic rd(input logic [7:0] a);
    cycle(1'b1, 1'b1, 1'b0, a, 16'h0000, 2'b00);
  endtask

  // Runs idle cycles until ready (bounded) and returns how many it took.
  task automatic wait_clear(output int n);
    n = 0;
    while (!bus.req_ready && n < 400) begin
      idle(1'b1);
      n++;
    end
  endtask

  initial begin
    int n;
    int n_rsp;
    logic [7:0]  a;
    logic [15:0] d;

    for (int i = 0; i < 3; i++) idle(1'b0);
    check("rst_busy",  32'(bus.busy), 32'd1);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    wait_clear(n);
    check("clr_len", 32'(n), 32'd200);

    rd(8'd0);   check("rd0",   32'(bus.rsp_rdata), 32'h0);
    rd(8'd99);  check("rd99",  32'(bus.rsp_rdata), 32'h0);
    rd(8'd199); check("rd199", 32'(bus.rsp_rdata), 32'h0);
    check("rd199_err", 32'(bus.rsp_err), 32'd0);

    wr(8'd5, 16'hABCD, 2'b11); rd(8'd5); check("full_wr",    32'(bus.rsp_rdata), 32'hABCD);
    wr(8'd5, 16'h1234, 2'b01); rd(8'd5); check("partial_wr", 32'(bus.rsp_rdata), 32'hAB34);
    wr(8'd5, 16'hFFFF, 2'b00); rd(8'd5); check("be0_wr",     32'(bus.rsp_rdata), 32'hAB34);

    wr(8'd7, 16'hBEEF, 2'b11);
    check("b2b_wr_valid", 32'(bus.rsp_valid), 32'd1);
    rd(8'd7);
    check("b2b_rd_valid", 32'(bus.rsp_valid), 32'd1);
    check("b2b_rd_data",  32'(bus.rsp_rdata), 32'hBEEF);

    n_rsp = 0;
    for (int i = 0; i < 25; i++) begin
      a = 8'($urandom_range(0, DEPTH - 1));
      wr(a, 16'($urandom), 2'($urandom));
      n_rsp += int'(bus.rsp_valid);
      rd(a);
      n_rsp += int'(bus.rsp_valid);
    end
    check("alt_rsp_cnt", 32'(n_rsp), 32'd50);

    wr(8'd200, 16'h5555, 2'b11); check("oor_wr_err", 32'(bus.rsp_err), 32'd1);
    rd(8'd255);
    check("oor_rd_err",  32'(bus.rsp_err),   32'd1);
    check("oor_rd_data", 32'(bus.rsp_rdata), 32'h0);
    rd(8'd199); check("post_oor_err", 32'(bus.rsp_err), 32'd0);

    for (int i = 0; i < 300; i++) begin
      a = ($urandom % 8 == 0) ? 8'($urandom_range(DEPTH, 255)) : 8'($urandom_range(0, DEPTH - 1));
      d = 16'($urandom);
      cycle(1'b1, ($urandom % 4) != 0, 1'($urandom), a, d, 2'($urandom));
    end

    idle(1'b0);
    for (int i = 0; i < 120; i++) idle(1'b1);
    check("midclr_busy", 32'(bus.busy), 32'd1);
    idle(1'b0);
    wait_clear(n);
    check("midclr_len", 32'(n), 32'd200);

    wr(8'd3, 16'h1111, 2'b11);
    cycle(1'b0, 1'b1, 1'b1, 8'd3, 16'h2222, 2'b11);
    check("rst_run_norsp", 32'(bus.rsp_valid), 32'd0);
    wait_clear(n);
    check("rst_run_len", 32'(n), 32'd200);
    rd(8'd3); check("rst_run_rd3", 32'(bus.rsp_rdata), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
